// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Requester handshake and FIFO write-port bundle for
//               fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int DW   = 140,
    parameter int N_CH = 4
);
    logic [N_CH-1:0]         in_valid;
    logic [N_CH*DW-1:0]      in_data;
    logic [N_CH-1:0]         in_last;
    logic [N_CH-1:0]         in_ready;
    logic                    fifo_full;
    logic                    fifo_w_enable;
    logic [DW-1:0]           data_to_fifo;
    logic                    grant_vld;
    logic [$clog2(N_CH)-1:0] grant_id;

    // Arbiter side
    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, fifo_w_enable, data_to_fifo, grant_vld, grant_id
    );

    // Requester / FIFO side
    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, fifo_w_enable, data_to_fifo, grant_vld, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port among N_CH
//               valid/ready requesters, with bursts capped at BURST_LEN words.
//               Optional macro FIFO_ARB_CH0_PRIO_EN gives channel 0 absolute
//               priority at every arbitration point.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DW        = 140,
    parameter int N_CH      = 4,
    parameter int BURST_LEN = 4
) (
    input  wire logic          clk_in,
    input  wire logic          rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int c_id_w  = $clog2(N_CH);
    localparam int c_cnt_w = $clog2(BURST_LEN) + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_id_w-1:0]   r_owner;
    logic [c_id_w-1:0]   r_ptr;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [DW-1:0]       w_slice [N_CH];
    logic                w_grant;
    logic                w_own_valid;
    logic                w_own_last;
    logic                w_acc;
    logic                w_release;
    logic [c_id_w-1:0]   w_pick;
    logic                w_pick_vld;
    logic [N_CH-1:0]     w_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_slice
            assign w_slice[gi] = bus.in_data[gi*DW +: DW];
        end
    endgenerate

    assign w_grant     = (r_state == ST_GRANT);
    assign w_own_valid = bus.in_valid[r_owner];
    assign w_own_last  = bus.in_last[r_owner];
    assign w_acc       = w_grant && w_own_valid && !bus.fifo_full;

    // A dropped valid ends the grant without a transfer
    assign w_release = w_grant &&
                       ((w_acc && (w_own_last || (r_cnt == c_cnt_w'(BURST_LEN-1)))) ||
                        !w_own_valid);

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ready[i] = w_grant && (r_owner == c_id_w'(i)) && !bus.fifo_full;
        end
    end

    // Scan from farthest to nearest so the channel right after ptr wins last
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % N_CH;
            if (bus.in_valid[idx]) begin
                w_pick     = c_id_w'(idx);
                w_pick_vld = 1'b1;
            end
        end
`ifdef FIFO_ARB_CH0_PRIO_EN
        if (bus.in_valid[0]) begin
            w_pick     = '0;
            w_pick_vld = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= c_id_w'(N_CH-1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick;
                        r_ptr   <= w_pick;
                        r_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_cnt <= '0;
                        if (w_pick_vld) begin
                            r_owner <= w_pick;
                            r_ptr   <= w_pick;
                        end else begin
                            r_state <= ST_IDLE;
                            r_owner <= '0;
                        end
                    end else if (w_acc) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_owner <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready      = w_ready;
    assign bus.fifo_w_enable = w_acc;
    assign bus.data_to_fifo  = w_acc ? w_slice[r_owner] : '0;
    assign bus.grant_vld     = w_grant;
    assign bus.grant_id      = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
    localparam int DW        = 140;
    localparam int N_CH      = 4;
    localparam int BURST_LEN = 4;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int seq  [N_CH];
    int lst  [N_CH];
    int stop [N_CH];
    int eseq [N_CH];

    fifo_wr_arbiter_if #(.DW(DW), .N_CH(N_CH)) bus ();

    fifo_wr_arbiter #(.DW(DW), .N_CH(N_CH), .BURST_LEN(BURST_LEN)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [DW-1:0] word(input int ch, input int s);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 8] = 8'hA5;
        w[23:16]     = ch[7:0];
        w[15:0]      = s[15:0];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_CH; i++) begin
            bus.in_data[i*DW +: DW] = word(i, seq[i]);
            bus.in_last[i] = (lst[i] != 0) && (seq[i] == lst[i] - 1);
            if (stop[i] != 0 && seq[i] >= stop[i]) bus.in_valid[i] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [N_CH-1:0] acc;
        acc = bus.in_valid & bus.in_ready;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < N_CH; i++) if (acc[i]) seq[i]++;
        drive();
    endtask

    task automatic look(input string tag, input logic we, input int dch, input int dseq,
                        input logic gv, input int gid, input logic [N_CH-1:0] rdy);
        @(negedge clk_in);
        chk({tag, " we"},    DW'(bus.fifo_w_enable), DW'(we));
        chk({tag, " data"},  bus.data_to_fifo, we ? word(dch, dseq) : '0);
        chk({tag, " gvld"},  DW'(bus.grant_vld), DW'(gv));
        chk({tag, " gid"},   DW'(bus.grant_id), DW'(gid));
        chk({tag, " ready"}, DW'(bus.in_ready), DW'(rdy));
    endtask

    task automatic burst(input int ch);
        for (int b = 0; b < BURST_LEN; b++) begin
            look($sformatf("burst ch%0d b%0d", ch, b), 1'b1, ch, eseq[ch], 1'b1, ch,
                 N_CH'(1 << ch));
            eseq[ch]++;
            tick();
        end
    endtask

    task automatic set_req(input int ch, input int l, input int s);
        seq[ch]  = 0;
        lst[ch]  = l;
        stop[ch] = s;
        bus.in_valid[ch] = 1'b1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            seq[i] = 0; lst[i] = 0; stop[i] = 0; eseq[i] = 0;
        end
        drive();
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked while rst is held
        rst = 1'b1;
        bus.in_valid  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            seq[i] = 0; lst[i] = 0; stop[i] = 0; eseq[i] = 0;
        end
        drive();
        @(posedge clk_in);
        #1;
        look("reset", 1'b0, 0, 0, 1'b0, 0, '0);
        rst = 1'b0;

        // Single 3-word packet from ch0
        do_reset();
        set_req(0, 3, 3);
        look("t1 idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
        for (int b = 0; b < 3; b++) begin
            look($sformatf("t1 w%0d", b), 1'b1, 0, b, 1'b1, 0, 4'b0001);
            tick();
        end
        look("t1 regrant drop", 1'b0, 0, 0, 1'b1, 0, 4'b0001);
        tick();
        look("t1 idle end", 1'b0, 0, 0, 1'b0, 0, '0);

        // All four channels streaming, no in_last
        do_reset();
        for (int i = 0; i < N_CH; i++) set_req(i, 0, 0);
        look("t2 idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
`ifdef FIFO_ARB_CH0_PRIO_EN
        burst(0); burst(0); burst(0); burst(0); burst(0);
        bus.in_valid = '0;
        look("t2 drop", 1'b0, 0, 0, 1'b1, 0, 4'b0001);
`else
        burst(0); burst(1); burst(2); burst(3); burst(0);
        bus.in_valid = '0;
        look("t2 drop", 1'b0, 0, 0, 1'b1, 1, 4'b0010);
`endif
        tick();
        look("t2 idle end", 1'b0, 0, 0, 1'b0, 0, '0);

        // ch1 stalled by fifo_full for 5 cycles mid-burst
        do_reset();
        set_req(1, 4, 4);
        look("t3 idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
        look("t3 w0", 1'b1, 1, 0, 1'b1, 1, 4'b0010);
        tick();
        look("t3 w1", 1'b1, 1, 1, 1'b1, 1, 4'b0010);
        tick();
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            look($sformatf("t3 stall%0d", s), 1'b0, 0, 0, 1'b1, 1, '0);
            tick();
        end
        bus.fifo_full = 1'b0;
        look("t3 w2", 1'b1, 1, 2, 1'b1, 1, 4'b0010);
        tick();
        look("t3 w3", 1'b1, 1, 3, 1'b1, 1, 4'b0010);
        tick();
        look("t3 regrant drop", 1'b0, 0, 0, 1'b1, 1, 4'b0010);
        tick();
        look("t3 idle end", 1'b0, 0, 0, 1'b0, 0, '0);

        // ch2 drops valid after 2 words, ch3 waiting
        do_reset();
        set_req(2, 0, 2);
        set_req(3, 0, 4);
        look("t4 idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
        look("t4 ch2 w0", 1'b1, 2, 0, 1'b1, 2, 4'b0100);
        tick();
        look("t4 ch2 w1", 1'b1, 2, 1, 1'b1, 2, 4'b0100);
        tick();
        look("t4 drop", 1'b0, 0, 0, 1'b1, 2, 4'b0100);
        tick();
        burst(3);
        look("t4 ch3 drop", 1'b0, 0, 0, 1'b1, 3, 4'b1000);
        tick();
        look("t4 idle end", 1'b0, 0, 0, 1'b0, 0, '0);

        // Asynchronous reset in cycle 2 of a ch0 burst, ch1 also requesting
        do_reset();
        set_req(0, 0, 0);
        set_req(1, 0, 0);
        look("t5 idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
        look("t5 w0", 1'b1, 0, 0, 1'b1, 0, 4'b0001);
        tick();
        look("t5 w1", 1'b1, 0, 1, 1'b1, 0, 4'b0001);
        #1;
        rst = 1'b1;
        #1;
        chk("t5 async we",    DW'(bus.fifo_w_enable), '0);
        chk("t5 async data",  bus.data_to_fifo, '0);
        chk("t5 async gvld",  DW'(bus.grant_vld), '0);
        chk("t5 async gid",   DW'(bus.grant_id), '0);
        chk("t5 async ready", DW'(bus.in_ready), '0);
        tick();
        rst = 1'b0;
        look("t5 post idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
        look("t5 regrant ch0", 1'b1, 0, 1, 1'b1, 0, 4'b0001);

        // ch0 and ch1 both streaming
        do_reset();
        set_req(0, 0, 0);
        set_req(1, 0, 0);
        look("t6 idle", 1'b0, 0, 0, 1'b0, 0, '0);
        tick();
`ifdef FIFO_ARB_CH0_PRIO_EN
        burst(0); burst(0); burst(0); burst(0);
`else
        burst(0); burst(1); burst(0); burst(1);
`endif
        bus.in_valid = '0;
        look("t6 drop", 1'b0, 0, 0, 1'b1, 0, 4'b0001);
        tick();
        look("t6 idle end", 1'b0, 0, 0, 1'b0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
